// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential binary-to-BCD converter built on the double-dabble (shift and
//   add-3) algorithm. A request is accepted in IDLE. Each CONV cycle then
//   performs one step, and the DONE cycle presents the result with a one-cycle
//   dout_vld pulse. A conversion takes W+2 cycles from acceptance back to the
//   next acceptance.
//
// Parameters
//   W           binary input width (1..16)
//   D           number of BCD output digits; 10^D must exceed 2^W-1
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   din         unsigned binary value to convert
//   din_vld     request; din is taken when din_vld=1 and rdy=1
//   rdy         high in IDLE only
//   dout        packed BCD result, digit k in bits [4k+3:4k]
//   dout_vld    one-cycle pulse marking a new dout
//   dout_blank  bit k set when digit k is a leading zero (bit 0 always 0)
//   drop        one-cycle pulse: a request arrived while busy and was ignored
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
    parameter int W = 8,
    parameter int D = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     din,
    input  logic             din_vld,
    output logic             rdy,
    output logic [4*D-1:0]   dout,
    output logic             dout_vld,
    output logic [D-1:0]     dout_blank,
    output logic             drop
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    // The shift register holds the BCD accumulator above the binary operand.
    localparam int SW = 4 * D + W;
    localparam logic [D-1:0] BLANK_RST = {D{1'b1}} << 1;

    // True when D decimal digits can represent every W-bit value.
    function automatic bit range_ok();
        longint unsigned max_val;
        longint unsigned pow10;
        max_val = (64'd1 << W) - 64'd1;
        pow10   = 64'd1;
        for (int i = 0; i < D; i++) begin
            // Saturate once the bound is met so large D cannot overflow.
            if (pow10 <= max_val) pow10 = pow10 * 64'd10;
        end
        return (W >= 1) && (W <= 16) && (pow10 > max_val);
    endfunction

    localparam bit RANGE_OK = range_ok();

    generate
        if (!RANGE_OK) begin : g_bad_params
            $fatal(1, "bin2bcd_seq: W must be 1..16 and 10^D must exceed 2^W-1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [SW-1:0]   sr;
    logic [SW-1:0]   adj;
    logic [SW-1:0]   step;
    logic [CW-1:0]   cnt;
    logic [D-1:0]    blank_nxt;
    logic            accept;
    logic            last_step;

    assign rdy       = (state == IDLE);
    assign dout_vld  = (state == DONE);
    assign accept    = rdy && din_vld;
    assign last_step = (state == CONV) && (cnt == '0);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (din_vld) state_nxt = CONV;
            CONV: if (cnt == '0) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // One double-dabble step: add 3 to each digit >= 5, then shift left.
    // A digit >= 5 becomes at most 12 after the add, so 4 bits suffice, and
    // after the shift every digit is back in 0..9.
    // -------------------------------------------------------------------------
    always_comb begin
        adj = sr;
        for (int k = 0; k < D; k++) begin
            if (sr[W+4*k +: 4] >= 4'd5) adj[W+4*k +: 4] = sr[W+4*k +: 4] + 4'd3;
        end
        step = {adj[SW-2:0], 1'b0};
    end

    // Leading-zero mask of the final result: digit k is blank when it and
    // every digit above it are zero. The units digit is never blanked.
    always_comb begin
        logic all_zero;
        blank_nxt = '0;
        all_zero  = 1'b1;
        for (int k = D - 1; k >= 1; k--) begin
            all_zero     = all_zero && (step[W+4*k +: 4] == 4'd0);
            blank_nxt[k] = all_zero;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr         <= '0;
            cnt        <= '0;
            dout       <= '0;
            dout_blank <= BLANK_RST;
            drop       <= 1'b0;
        end else begin
            // A request while busy is discarded and reported one cycle later.
            drop <= din_vld && !rdy;

            if (accept) begin
                sr  <= SW'(din);
                cnt <= CW'(W - 1);
            end else if (state == CONV) begin
                sr  <= step;
                cnt <= cnt - CW'(1);
            end

            // Outputs change only on the final step, so they hold through CONV.
            if (last_step) begin
                dout       <= step[SW-1:W];
                dout_blank <= blank_nxt;
            end
        end
    end

endmodule
